reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//  Shares one register-bus slave (wr_req/wr_ack, rd_req/rd_ack handshake) between C_NUM_REQ requesters,
//  e.g. the AXI4-Lite IPIF plus a local init sequencer. Round-robin over requesters, one transaction in
//  flight at a time, registered slave-side outputs. Sits between bus bridges and the register file.
// PARAMETERS
//  C_NUM_REQ     2    number of requesters, 2..4
//  C_ADDR_WIDTH  12   byte address width; word address is C_ADDR_WIDTH-2 bits (AW below)
//  C_DATA_WIDTH  32   data width, 32 or 64 (DW below)
//  C_TIMEOUT     256  slave ack timeout in cycles, 2..65535 (used only with REG_ARB_TIMEOUT_EN)
// PORTS
//  aclk       in   1       clock
//  areset     in   1       asynchronous reset, active-high
//  s_wr_addr  in   N*AW    requester i word address, slice i
//  s_wr_req   in   N       write request level, held until s_wr_ack[i]
//  s_wr_be    in   N*4     byte enables, slice i
//  s_wr_data  in   N*DW    write data, slice i
//  s_wr_ack   out  N       one-cycle write completion pulse
//  s_rd_addr  in   N*AW    read word address, slice i
//  s_rd_req   in   N       read request level, held until s_rd_ack[i]
//  s_rd_data  out  DW      read data, shared, valid when any s_rd_ack bit is high
//  s_rd_ack   out  N       one-cycle read completion pulse
//  s_err      out  N       one-cycle pulse with s_wr_ack/s_rd_ack when transaction timed out
//  m_wr_addr  out  AW      slave write address
//  m_wr_req   out  1       slave write request level
//  m_wr_be    out  4       slave byte enables
//  m_wr_data  out  DW      slave write data
//  m_wr_ack   in   1       slave write acknowledge
//  m_rd_addr  out  AW      slave read address
//  m_rd_req   out  1       slave read request level
//  m_rd_data  in   DW      slave read data, valid with m_rd_ack
//  m_rd_ack   in   1       slave read acknowledge
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 0, all per-requester last-op bits = read.
//  States: IDLE -> WR | RD -> DONE -> IDLE.
//  IDLE: candidates = requesters with s_wr_req|s_rd_req. Grant first candidate at or after rr pointer
//   (modulo N); rr pointer <= granted+1 mod N. Within granted requester, if both wr and rd pending:
//   opposite of its last-op bit (write wins after a read, read wins after a write); else the pending one.
//   Granted requester's address/be/data are captured into m_* regs; m_wr_req or m_rd_req goes high next cycle.
//  WR/RD: m_*_req held high, m_* addr/data stable until m_*_ack. Acks for the non-active op are ignored.
//   Slave ack in cycle k -> m_*_req low in k+1, state DONE in k+1.
//  DONE (1 cycle): s_wr_ack[g] or s_rd_ack[g] high; s_rd_data = m_rd_data captured on m_rd_ack.
//   Granted requester's req is still high this cycle and must not be re-granted; next arbitration in IDLE.
//  Latency: req seen in IDLE at cycle 0, slave acks same cycle req appears (cycle 1) -> s ack in cycle 2.
//  Minimum issue interval 3 cycles. s_rd_data holds last value between reads.
//  Requester dropping req before its ack is illegal; transaction still completes and ack is still pulsed.
//  areset mid-transaction: immediate return to IDLE, m_*_req dropped, no ack issued.
// CONFIGURATION
//  REG_ARB_TIMEOUT_EN defined: 16-bit counter cleared on entering WR/RD, increments each cycle there;
//   reaching C_TIMEOUT with no ack -> drop m_*_req, go DONE, pulse s_*_ack[g] and s_err[g], s_rd_data = 0.
//   Ack arriving in the same cycle as expiry counts as normal completion (no s_err).
//  Not defined: no counter, WR/RD wait indefinitely, s_err tied to 0.
// TESTING
//  1. Req0 write addr 0x010 data 0xA5A5A5A5 be 0xF, slave acks 1st cycle -> m_wr_req 1 cycle, s_wr_ack[0] at cycle 2.
//  2. Req0 and req1 reads held continuously, slave ack latency 3 -> grants alternate 0,1,0,1; no starvation.
//  3. Req1 wr and rd asserted together, last-op=read -> write served first, then read; s_rd_data = m_rd_data.
//  4. Slave ack delayed 10 cycles -> m_wr_addr/data stable throughout; no other requester granted meanwhile.
//  5. REG_ARB_TIMEOUT_EN, C_TIMEOUT=16, slave never acks -> s_rd_ack[0]+s_err[0] 17 cycles after grant, data 0.
//  6. areset during RD -> m_rd_req low, busy 0 immediately, no s_rd_ack; pending req re-granted after release.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register-bus slave between C_NUM_REQ requesters.
// Round-robin grant, one transaction in flight, registered slave-side outputs.
// Optional feature macro: REG_ARB_TIMEOUT_EN (slave ack timeout with s_err pulse).
//
// Handshake: every *_req is a level held by the initiator until the matching
// *_ack pulse (one cycle) is seen; the responder may ack in the first cycle
// the req is visible. Address/data/be must stay stable while req is high.
module reg_bus_arbiter #(
    parameter int C_NUM_REQ    = 2,
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                                    aclk,
    input  logic                                    areset,
    input  logic [C_NUM_REQ*(C_ADDR_WIDTH-2)-1:0]   s_wr_addr,
    input  logic [C_NUM_REQ-1:0]                    s_wr_req,
    input  logic [C_NUM_REQ*4-1:0]                  s_wr_be,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0]       s_wr_data,
    output logic [C_NUM_REQ-1:0]                    s_wr_ack,
    input  logic [C_NUM_REQ*(C_ADDR_WIDTH-2)-1:0]   s_rd_addr,
    input  logic [C_NUM_REQ-1:0]                    s_rd_req,
    output logic [C_DATA_WIDTH-1:0]                 s_rd_data,
    output logic [C_NUM_REQ-1:0]                    s_rd_ack,
    output logic [C_NUM_REQ-1:0]                    s_err,
    output logic [C_ADDR_WIDTH-3:0]                 m_wr_addr,
    output logic                                    m_wr_req,
    output logic [3:0]                              m_wr_be,
    output logic [C_DATA_WIDTH-1:0]                 m_wr_data,
    input  logic                                    m_wr_ack,
    output logic [C_ADDR_WIDTH-3:0]                 m_rd_addr,
    output logic                                    m_rd_req,
    input  logic [C_DATA_WIDTH-1:0]                 m_rd_data,
    input  logic                                    m_rd_ack,
    output logic                                    busy,
    output logic [1:0]                              dbg_state
);

    localparam int N  = C_NUM_REQ;
    localparam int AW = C_ADDR_WIDTH - 2;
    localparam int DW = C_DATA_WIDTH;
    localparam int IW = (N > 2) ? 2 : 1;

    // Elaboration-time guard on the supported parameter ranges.
    if (C_NUM_REQ < 2 || C_NUM_REQ > 4 || (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) ||
        C_TIMEOUT < 2 || C_TIMEOUT > 65535) begin : g_bad_param
        $error("reg_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [N-1:0]    last_wr_q, last_wr_d;   // 1 = last op of requester was a write
    logic [AW-1:0]   m_wr_addr_q, m_wr_addr_d;
    logic            m_wr_req_q, m_wr_req_d;
    logic [3:0]      m_wr_be_q, m_wr_be_d;
    logic [DW-1:0]   m_wr_data_q, m_wr_data_d;
    logic [AW-1:0]   m_rd_addr_q, m_rd_addr_d;
    logic            m_rd_req_q, m_rd_req_d;
    logic [N-1:0]    s_wr_ack_q, s_wr_ack_d;
    logic [N-1:0]    s_rd_ack_q, s_rd_ack_d;
    logic [DW-1:0]   s_rd_data_q, s_rd_data_d;

`ifdef REG_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic [N-1:0]    s_err_q, s_err_d;
    logic            tmo_hit;
    // Counter shows C_TIMEOUT-1 in the last waiting cycle; expiry takes effect at that edge.
    assign tmo_hit = (cnt_q == 16'(C_TIMEOUT - 1));
`endif

    // Per-requester views of the flattened request buses.
    logic [AW-1:0]   wr_addr_a [N];
    logic [3:0]      wr_be_a   [N];
    logic [DW-1:0]   wr_data_a [N];
    logic [AW-1:0]   rd_addr_a [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign wr_addr_a[i] = s_wr_addr[i*AW +: AW];
        assign wr_be_a[i]   = s_wr_be[i*4 +: 4];
        assign wr_data_a[i] = s_wr_data[i*DW +: DW];
        assign rd_addr_a[i] = s_rd_addr[i*AW +: AW];
    end

    logic [N-1:0]    cand;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   rr_nxt;
    logic            gnt_is_wr;

    // Round-robin pick: first requester with any pending op at or after rr_q.
    always_comb begin : arb
        logic [IW:0] sum;
        sum     = '0;
        cand    = s_wr_req | s_rd_req;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, rr_q} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!gnt_vld && cand[sum[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[IW-1:0];
            end
        end
        sum = {1'b0, gnt_idx} + (IW+1)'(1);
        if (sum >= (IW+1)'(N)) begin
            sum = '0;
        end
        rr_nxt = sum[IW-1:0];
        // With both ops pending, alternate against the requester's previous op.
        gnt_is_wr = s_wr_req[gnt_idx] & (~s_rd_req[gnt_idx] | ~last_wr_q[gnt_idx]);
    end

    // Next-state and output-register logic of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        last_wr_d   = last_wr_q;
        m_wr_addr_d = m_wr_addr_q;
        m_wr_req_d  = m_wr_req_q;
        m_wr_be_d   = m_wr_be_q;
        m_wr_data_d = m_wr_data_q;
        m_rd_addr_d = m_rd_addr_q;
        m_rd_req_d  = m_rd_req_q;
        s_wr_ack_d  = '0;
        s_rd_ack_d  = '0;
        s_rd_data_d = s_rd_data_q;
`ifdef REG_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        s_err_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    gnt_d = gnt_idx;
                    rr_d  = rr_nxt;
`ifdef REG_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (gnt_is_wr) begin
                        state_d            = ST_WR;
                        m_wr_req_d         = 1'b1;
                        m_wr_addr_d        = wr_addr_a[gnt_idx];
                        m_wr_be_d          = wr_be_a[gnt_idx];
                        m_wr_data_d        = wr_data_a[gnt_idx];
                        last_wr_d[gnt_idx] = 1'b1;
                    end else begin
                        state_d            = ST_RD;
                        m_rd_req_d         = 1'b1;
                        m_rd_addr_d        = rd_addr_a[gnt_idx];
                        last_wr_d[gnt_idx] = 1'b0;
                    end
                end
            end
            ST_WR: begin
`ifdef REG_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (m_wr_ack) begin
                    m_wr_req_d        = 1'b0;
                    s_wr_ack_d[gnt_q] = 1'b1;
                    state_d           = ST_DONE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    m_wr_req_d        = 1'b0;
                    s_wr_ack_d[gnt_q] = 1'b1;
                    s_err_d[gnt_q]    = 1'b1;
                    state_d           = ST_DONE;
                end
`endif
            end
            ST_RD: begin
`ifdef REG_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (m_rd_ack) begin
                    m_rd_req_d        = 1'b0;
                    s_rd_ack_d[gnt_q] = 1'b1;
                    s_rd_data_d       = m_rd_data;
                    state_d           = ST_DONE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    // A timed-out read returns zero rather than stale data.
                    m_rd_req_d        = 1'b0;
                    s_rd_ack_d[gnt_q] = 1'b1;
                    s_err_d[gnt_q]    = 1'b1;
                    s_rd_data_d       = '0;
                    state_d           = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                // Ack pulse cycle; the granted req is still high, so no arbitration here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without an ack.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            last_wr_q   <= '0;
            m_wr_addr_q <= '0;
            m_wr_req_q  <= 1'b0;
            m_wr_be_q   <= '0;
            m_wr_data_q <= '0;
            m_rd_addr_q <= '0;
            m_rd_req_q  <= 1'b0;
            s_wr_ack_q  <= '0;
            s_rd_ack_q  <= '0;
            s_rd_data_q <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            s_err_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            last_wr_q   <= last_wr_d;
            m_wr_addr_q <= m_wr_addr_d;
            m_wr_req_q  <= m_wr_req_d;
            m_wr_be_q   <= m_wr_be_d;
            m_wr_data_q <= m_wr_data_d;
            m_rd_addr_q <= m_rd_addr_d;
            m_rd_req_q  <= m_rd_req_d;
            s_wr_ack_q  <= s_wr_ack_d;
            s_rd_ack_q  <= s_rd_ack_d;
            s_rd_data_q <= s_rd_data_d;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            s_err_q     <= s_err_d;
`endif
        end
    end

    assign m_wr_addr = m_wr_addr_q;
    assign m_wr_req  = m_wr_req_q;
    assign m_wr_be   = m_wr_be_q;
    assign m_wr_data = m_wr_data_q;
    assign m_rd_addr = m_rd_addr_q;
    assign m_rd_req  = m_rd_req_q;
    assign s_wr_ack  = s_wr_ack_q;
    assign s_rd_ack  = s_rd_ack_q;
    assign s_rd_data = s_rd_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
`ifdef REG_ARB_TIMEOUT_EN
    assign s_err     = s_err_q;
`else
    assign s_err     = '0;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed test of reg_bus_arbiter with a behavioural slave
// and an ack scoreboard. Build with REG_ARB_TIMEOUT_EN to include the timeout test.
module tb_reg_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W  = 38;   // {s_err, s_wr_ack, s_rd_ack, rd_data}

  // ---------------- clock / reset ----------------
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- DUT ----------------
  logic [N*AW-1:0] s_wr_addr = '0;
  logic [N-1:0]    s_wr_req  = '0;
  logic [N*4-1:0]  s_wr_be   = '0;
  logic [N*DW-1:0] s_wr_data = '0;
  logic [N-1:0]    s_wr_ack;
  logic [N*AW-1:0] s_rd_addr = '0;
  logic [N-1:0]    s_rd_req  = '0;
  logic [DW-1:0]   s_rd_data;
  logic [N-1:0]    s_rd_ack;
  logic [N-1:0]    s_err;
  logic [AW-1:0]   m_wr_addr;
  logic            m_wr_req;
  logic [3:0]      m_wr_be;
  logic [DW-1:0]   m_wr_data;
  logic            m_wr_ack = 1'b0;
  logic [AW-1:0]   m_rd_addr;
  logic            m_rd_req;
  logic [DW-1:0]   m_rd_data = '0;
  logic            m_rd_ack = 1'b0;
  logic            busy;
  logic [1:0]      dbg_state;

  reg_bus_arbiter #(
    .C_NUM_REQ    (N),
    .C_ADDR_WIDTH (AW + 2),
    .C_DATA_WIDTH (DW),
    .C_TIMEOUT    (16)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_wr_addr (s_wr_addr),
    .s_wr_req  (s_wr_req),
    .s_wr_be   (s_wr_be),
    .s_wr_data (s_wr_data),
    .s_wr_ack  (s_wr_ack),
    .s_rd_addr (s_rd_addr),
    .s_rd_req  (s_rd_req),
    .s_rd_data (s_rd_data),
    .s_rd_ack  (s_rd_ack),
    .s_err     (s_err),
    .m_wr_addr (m_wr_addr),
    .m_wr_req  (m_wr_req),
    .m_wr_be   (m_wr_be),
    .m_wr_data (m_wr_data),
    .m_wr_ack  (m_wr_ack),
    .m_rd_addr (m_rd_addr),
    .m_rd_req  (m_rd_req),
    .m_rd_data (m_rd_data),
    .m_rd_ack  (m_rd_ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic [1:0] err, input logic [1:0] wr,
                                          input logic [1:0] rd, input logic [31:0] data);
    return {err, wr, rd, data};
  endfunction

  // ---------------- slave model ----------------
  // Acks after slave_lat extra cycles of req (0 = same cycle the req is seen).
  int slave_lat = 0;
  logic [31:0] mem [1024];

  initial begin
    int wcnt;
    int rcnt;
    wcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    forever begin
      @(posedge aclk);
      #1;
      m_wr_ack  = 1'b0;
      m_rd_ack  = 1'b0;
      m_rd_data = 32'hBAD0_BAD0;
      if (m_wr_req) begin
        if (wcnt >= slave_lat) begin
          m_wr_ack = 1'b1;
          wcnt = 0;
          for (int b = 0; b < 4; b++)
            if (m_wr_be[b]) mem[m_wr_addr][b*8 +: 8] = m_wr_data[b*8 +: 8];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (m_rd_req) begin
        if (rcnt >= slave_lat) begin
          m_rd_ack  = 1'b1;
          m_rd_data = mem[m_rd_addr];
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(posedge aclk);
    #1;
    if (|s_wr_ack || |s_rd_ack || |s_err) begin
      got = {s_err, s_wr_ack, s_rd_ack, (|s_rd_ack) ? s_rd_data : 32'h0};
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_ack", 64'(got), 64'(0));
      end else begin
        exp = exp_q.pop_front();
        check_eq("sb_ack", 64'(got), 64'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_wr(input int i, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    s_wr_addr[i*AW +: AW] = addr;
    s_wr_data[i*DW +: DW] = data;
    s_wr_be[i*4 +: 4]     = be;
    s_wr_req[i]           = 1'b1;
  endtask

  task automatic drive_rd(input int i, input logic [AW-1:0] addr);
    s_rd_addr[i*AW +: AW] = addr;
    s_rd_req[i]           = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    int c1;
    int last;

    // Reset state
    tick();
    tick();
    check_eq("rst_busy",      64'(busy),      64'(0));
    check_eq("rst_state",     64'(dbg_state), 64'(0));
    check_eq("rst_m_wr_req",  64'(m_wr_req),  64'(0));
    check_eq("rst_m_rd_req",  64'(m_rd_req),  64'(0));
    check_eq("rst_s_acks",    64'({s_wr_ack, s_rd_ack, s_err}), 64'(0));
    check_eq("rst_rd_data",   64'(s_rd_data), 64'(0));
    check_eq("rst_m_wr_addr", 64'(m_wr_addr), 64'(0));
    areset = 1'b0;
    tick();

    // Test 1: single write, slave acks immediately
    slave_lat = 0;
    exp_q.push_back(mk_exp(2'b00, 2'b01, 2'b00, 32'h0));
    drive_wr(0, 10'h010, 32'hA5A5_A5A5, 4'hF);
    check_eq("t1_idle_busy", 64'(busy), 64'(0));
    tick();  // cycle 1
    check_eq("t1_m_wr_req",  64'(m_wr_req),  64'(1));
    check_eq("t1_m_wr_addr", 64'(m_wr_addr), 64'(10'h010));
    check_eq("t1_m_wr_data", 64'(m_wr_data), 64'(32'hA5A5_A5A5));
    check_eq("t1_m_wr_be",   64'(m_wr_be),   64'(4'hF));
    check_eq("t1_no_ack_c1", 64'(s_wr_ack),  64'(0));
    tick();  // cycle 2
    check_eq("t1_m_wr_req_low", 64'(m_wr_req), 64'(0));
    check_eq("t1_s_wr_ack_c2",  64'(s_wr_ack), 64'(2'b01));
    s_wr_req[0] = 1'b0;
    tick();  // cycle 3
    check_eq("t1_ack_pulse", 64'(s_wr_ack), 64'(0));
    check_eq("t1_idle",      64'(busy),     64'(0));

    // Test 3: req1 write+read together, last op read -> write first
    exp_q.push_back(mk_exp(2'b00, 2'b10, 2'b00, 32'h0));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b10, 32'hC034_5640));
    drive_wr(1, 10'h040, 32'h1234_5678, 4'b0110);
    drive_rd(1, 10'h040);
    tick();
    check_eq("t3_wr_first",  64'(m_wr_req), 64'(1));
    check_eq("t3_rd_wait",   64'(m_rd_req), 64'(0));
    check_eq("t3_m_wr_be",   64'(m_wr_be),  64'(4'b0110));
    tick();
    check_eq("t3_s_wr_ack",  64'(s_wr_ack), 64'(2'b10));
    s_wr_req[1] = 1'b0;
    tick();
    tick();
    check_eq("t3_rd_next",   64'(m_rd_req),  64'(1));
    check_eq("t3_m_rd_addr", 64'(m_rd_addr), 64'(10'h040));
    tick();
    check_eq("t3_s_rd_ack",  64'(s_rd_ack),  64'(2'b10));
    check_eq("t3_rd_data",   64'(s_rd_data), 64'(32'hC034_5640));
    s_rd_req[1] = 1'b0;
    tick();
    check_eq("t3_rd_hold",   64'(s_rd_data), 64'(32'hC034_5640));

    // Test 2: both requesters read continuously, slave ack latency 3
    slave_lat = 2;
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b01, 32'hC0DE_0020));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b10, 32'hC0DE_0030));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b01, 32'hC0DE_0020));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b10, 32'hC0DE_0030));
    drive_rd(0, 10'h020);
    drive_rd(1, 10'h030);
    c0 = 0;
    c1 = 0;
    last = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (s_rd_ack[0]) c0++;
      if (s_rd_ack[1]) c1++;
      if (c0 == 2) s_rd_req[0] = 1'b0;
      if (c1 == 2) s_rd_req[1] = 1'b0;
      if (c0 == 2 && c1 == 2) begin
        last = n;
        break;
      end
    end
    check_eq("t2_last_ack_cycle", 64'(last), 64'(19));
    s_rd_req = '0;
    tick();

    // Test 4: write acked after 10 cycles, competing read must wait
    slave_lat = 9;
    exp_q.push_back(mk_exp(2'b00, 2'b01, 2'b00, 32'h0));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b10, 32'hDEAD_BEEF));
    drive_wr(0, 10'h055, 32'hDEAD_BEEF, 4'hF);
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 2) drive_rd(1, 10'h055);
      check_eq("t4_wr_req_held", 64'(m_wr_req),  64'(1));
      check_eq("t4_addr_stable", 64'(m_wr_addr), 64'(10'h055));
      check_eq("t4_data_stable", 64'(m_wr_data), 64'(32'hDEAD_BEEF));
      check_eq("t4_no_rd_grant", 64'(m_rd_req),  64'(0));
    end
    tick();  // cycle 11
    check_eq("t4_wr_req_low", 64'(m_wr_req), 64'(0));
    check_eq("t4_s_wr_ack",   64'(s_wr_ack), 64'(2'b01));
    s_wr_req[0] = 1'b0;
    slave_lat = 0;
    tick();  // cycle 12: IDLE
    check_eq("t4_idle_gap", 64'(busy), 64'(0));
    tick();  // cycle 13
    check_eq("t4_rd_granted", 64'(m_rd_req), 64'(1));
    tick();  // cycle 14
    check_eq("t4_s_rd_ack", 64'(s_rd_ack), 64'(2'b10));
    s_rd_req[1] = 1'b0;
    tick();

    // Test 6: reset during a read, then re-grant after release
    slave_lat = 1000;
    exp_q.push_back(mk_exp(2'b00, 2'b00, 2'b01, 32'hC0DE_0060));
    drive_rd(0, 10'h060);
    tick();
    check_eq("t6_rd_req", 64'(m_rd_req), 64'(1));
    tick();
    tick();
    areset = 1'b1;
    #1;
    check_eq("t6_rst_rd_req", 64'(m_rd_req), 64'(0));
    check_eq("t6_rst_busy",   64'(busy),     64'(0));
    check_eq("t6_rst_no_ack", 64'(s_rd_ack), 64'(0));
    slave_lat = 0;
    tick();
    check_eq("t6_rst_hold", 64'(m_rd_req), 64'(0));
    areset = 1'b0;
    tick();
    check_eq("t6_regrant",      64'(m_rd_req),  64'(1));
    check_eq("t6_regrant_addr", 64'(m_rd_addr), 64'(10'h060));
    tick();
    check_eq("t6_s_rd_ack", 64'(s_rd_ack), 64'(2'b01));
    s_rd_req[0] = 1'b0;
    tick();

`ifdef REG_ARB_TIMEOUT_EN
    // Test 5: slave never acks, timeout after 16 cycles of waiting
    slave_lat = 1000;
    exp_q.push_back(mk_exp(2'b01, 2'b00, 2'b01, 32'h0));
    drive_rd(0, 10'h070);
    last = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (|s_rd_ack) begin
        last = n;
        break;
      end
    end
    check_eq("t5_tmo_cycle", 64'(last),      64'(17));
    check_eq("t5_s_err",     64'(s_err),     64'(2'b01));
    check_eq("t5_rd_zero",   64'(s_rd_data), 64'(0));
    check_eq("t5_req_low",   64'(m_rd_req),  64'(0));
    s_rd_req[0] = 1'b0;
    slave_lat = 0;
    tick();
`endif

    // Final report
    tick();
    tick();
    check_eq("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
